cmp_nch_pipe: RTL
=================

# cmp_nch_pipe

Parametrised N-channel magnitude comparator that supersedes the single-channel equality check used for loop-index tests in the sigmoid/tanh datapath. Each cycle it compares a shared reference `M` against `CH` packed operands under a selectable relation. It registers the per-channel results, then reduces them to any, all and first-hit index, with valid tracking and a sticky hit flag. It sits in `common/` and feeds the sequencing control of the activation units.

## Interface
Parameters:
- `MW`, 5, operand width in bits (≥1)
- `CH`, 4, channel count (≥2)
- `IW`, 2, index width; must satisfy 2^IW ≥ CH

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  sample enable; qualifies the inputs this cycle
- `mode`  in  3  relation: 000 EQ, 001 NE, 010 LT, 011 LE, 100 GT, 101 GE, 110/111 reserved
- `sgn`  in  1  signed compare request; only honoured with `CMP_SIGNED_EN`
- `M`  in  MW  reference operand
- `j`  in  CH*MW  packed operands; channel k is `j[k*MW +: MW]`
- `clr`  in  1  synchronous clear of `seen`
- `hit`  out  CH  per-channel result; bit k set when the relation `j_k REL M` holds (e.g. LT: j_k < M)
- `any`  out  1  OR of `hit`
- `all`  out  1  AND of `hit`
- `first_idx`  out  IW  lowest k with hit[k]=1; 0 when none
- `valid`  out  1  outputs above correspond to an accepted sample
- `seen`  out  1  sticky: any accepted result since last clr/reset had `any`=1

## Operation
- Internal gate `EN = en & rst_n`. Only the stage-1 capture is gated by `EN`.
- Stage 1, registered on each edge:
  - `v1 <= EN`.
  - `h1[k] <=` relation result when EN=1, else 0.
  - `mode`, `M` and `j` are sampled only on this edge.
- Stage 2, registered on each edge:
  - `valid <= v1` and `hit <= h1`.
  - `any`, `all` and `first_idx` are computed from `h1` and registered together with `hit`.
- Outputs with `v1`=0 in the previous cycle:
  - `valid`, `hit`, `any` and `first_idx` are 0.
  - `all` is 0 whenever `valid`=0; it is not the vacuous-true AND.
- Reserved mode (110/111): all `h1` bits are 0, so the result has `valid`=1 and `any`=0.
- Unsigned compare is the default; full MW-bit magnitude, no truncation or wrap.
- `seen` update: `seen <= (seen & ~clr) | (v1 & |h1)`.
  - Simultaneous clr and a new hit leaves `seen`=1.
  - clr alone clears `seen` on the next edge.
- Reset (rst_n low, asynchronous): all registers 0, i.e. `hit`, `any`, `all`, `first_idx`, `valid`, `seen` and the stage-1 state. Asserting it mid-pipeline discards in-flight samples. After release, the first sample with en=1 yields `valid` two edges later.

## Timing
- Latency: 2 clocks from the edge that samples en=1 to `valid`=1 with its results.
- Throughput: 1 sample per clock. Back-to-back samples produce back-to-back `valid`.
- No backpressure: outputs are held for exactly one cycle per sample, and the consumer must capture them while `valid`=1.
- A bubble (en=0) propagates as a single-cycle `valid`=0 with zeroed outputs.
- `seen` reflects a hit in the same cycle that `valid`/`any` show it.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `CMP_SIGNED_EN` defined:
  - When `sgn`=1, operands and `M` are compared as two's-complement MW-bit values.
  - When `sgn`=0, the compare is unsigned.
  - `sgn` is sampled in stage 1 with `mode`.
- Not defined: `sgn` is ignored and all comparisons are unsigned; the port remains for interface stability.

## Test plan
- Reset/EQ:
  - Stimulus: rst_n low then high; MW=5, CH=4, mode=000, M=5'd9, j={9,3,9,0} (ch3..ch0), en=1 for one cycle.
  - Response: two edges later valid=1, hit=4'b1010, any=1, all=0, first_idx=1, seen=1; next cycle valid=0, hit=0.
- Relations:
  - Stimulus: M=16, j={31,16,15,0}, modes LT, LE, GT, GE, NE back-to-back.
  - Response: consecutive valid cycles with hit = 0011, 0111, 1000, 1100, 1011 respectively.
- Bubble/reserved:
  - Stimulus: en pattern 1,0,1 with the second sample at mode=111.
  - Response: valid 1,0,1; the reserved sample gives hit=0, any=0, all=0, first_idx=0.
- Sticky:
  - Stimulus: a hit sets seen; clr=1 alone; then clr=1 in the same cycle as a new hit's stage-1 cycle.
  - Response: seen 1 → 0 → 1.
- Async reset mid-flight:
  - Stimulus: assert rst_n one cycle after en=1 with matching inputs.
  - Response: all outputs 0 immediately; no valid pulse appears after release.
- Signed (`CMP_SIGNED_EN`):
  - Stimulus: sgn=1, mode=LT, M=5'd1, j_0=5'b11111 (−1).
  - Response: hit[0]=1.
  - With sgn=0 (or macro undefined), the same inputs give hit[0]=0.

Source files
------------

// File: rtl/cmp_nch_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cmp_nch_pipe
// Purpose  : N-channel magnitude comparator. A shared reference M is compared
//            against CH packed operands under a selectable relation. The
//            per-channel results are registered, then reduced to any / all /
//            first-hit index. The design also tracks valid and keeps a sticky
//            hit flag.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            en         - sample enable for the inputs this cycle
//            mode[2:0]  - relation: EQ NE LT LE GT GE (110/111 reserved)
//            sgn        - signed compare request (needs CMP_SIGNED_EN)
//            M[MW-1:0]  - reference operand
//            j[CH*MW-1:0] - packed operands, channel k = j[k*MW +: MW]
//            clr        - synchronous clear of seen
//            hit[CH-1:0], any, all, first_idx[IW-1:0], valid, seen - results
// Macro    : CMP_SIGNED_EN - when defined, sgn=1 selects a two's-complement
//            compare. When it is not defined, sgn is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_nch_pipe #(
    parameter int MW = 5,
    parameter int CH = 4,
    parameter int IW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sgn,
    input  logic [MW-1:0]    M,
    input  logic [CH*MW-1:0] j,
    input  logic             clr,
    output logic [CH-1:0]    hit,
    output logic             any,
    output logic             all,
    output logic [IW-1:0]    first_idx,
    output logic             valid,
    output logic             seen
);

    localparam logic [2:0] c_MODE_EQ = 3'b000;
    localparam logic [2:0] c_MODE_NE = 3'b001;
    localparam logic [2:0] c_MODE_LT = 3'b010;
    localparam logic [2:0] c_MODE_LE = 3'b011;
    localparam logic [2:0] c_MODE_GT = 3'b100;
    localparam logic [2:0] c_MODE_GE = 3'b101;

    logic          w_en;
    logic [MW-1:0] w_flip;
    logic [CH-1:0] w_rel;
    logic [IW-1:0] w_first;
    logic          w_found;

    logic          r_v1;
    logic [CH-1:0] r_h1;
    logic [CH-1:0] r_hit;
    logic          r_any;
    logic          r_all;
    logic [IW-1:0] r_first;
    logic          r_valid;
    logic          r_seen;

    // The capture qualifier also depends on rst_n. An enable that overlaps
    // reset release therefore cannot slip a sample into stage 1.
    assign w_en = en & rst_n;

`ifdef CMP_SIGNED_EN
    // A signed compare is done as an unsigned compare after the sign bit of
    // both operands is inverted. This maps two's-complement order onto
    // unsigned order, so both modes share one comparator per channel.
    assign w_flip = MW'(sgn) << (MW - 1);
`else
    logic w_unused_sgn;
    assign w_unused_sgn = sgn;
    assign w_flip       = '0;
`endif

    genvar gk;
    generate
        for (gk = 0; gk < CH; gk++) begin : g_ch
            logic [MW-1:0] w_a;
            logic [MW-1:0] w_b;
            logic          w_lt;
            logic          w_eq;
            logic          w_rel_k;

            assign w_a  = j[gk*MW +: MW] ^ w_flip;
            assign w_b  = M ^ w_flip;
            assign w_lt = (w_a < w_b);
            assign w_eq = (w_a == w_b);

            always_comb begin
                w_rel_k = 1'b0;
                case (mode)
                    c_MODE_EQ: w_rel_k = w_eq;
                    c_MODE_NE: w_rel_k = ~w_eq;
                    c_MODE_LT: w_rel_k = w_lt;
                    c_MODE_LE: w_rel_k = w_lt | w_eq;
                    c_MODE_GT: w_rel_k = ~(w_lt | w_eq);
                    c_MODE_GE: w_rel_k = ~w_lt;
                    default:   w_rel_k = 1'b0;  // reserved: never a hit
                endcase
            end

            assign w_rel[gk] = w_rel_k;
        end
    endgenerate

    // Stage 1: capture the relation results. An idle cycle captures zeros, so
    // the reductions downstream need no separate masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_h1 <= '0;
        end else begin
            r_v1 <= w_en;
            r_h1 <= w_en ? w_rel : '0;
        end
    end

    // Priority encoder. It returns the lowest set channel, or 0 when no
    // channel is set.
    always_comb begin
        w_first = '0;
        w_found = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (r_h1[k] && !w_found) begin
                w_first = IW'(k);
                w_found = 1'b1;
            end
        end
    end

    // Stage 2: register the hit vector together with its reductions.
    // The all output is qualified by r_v1, so a bubble never reports the
    // vacuous-true AND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_hit   <= '0;
            r_any   <= 1'b0;
            r_all   <= 1'b0;
            r_first <= '0;
            r_seen  <= 1'b0;
        end else begin
            r_valid <= r_v1;
            r_hit   <= r_h1;
            r_any   <= |r_h1;
            r_all   <= r_v1 & (&r_h1);
            r_first <= w_first;
            // A new hit wins over a simultaneous clear.
            r_seen  <= (r_seen & ~clr) | (r_v1 & (|r_h1));
        end
    end

    assign hit       = r_hit;
    assign any       = r_any;
    assign all       = r_all;
    assign first_idx = r_first;
    assign valid     = r_valid;
    assign seen      = r_seen;

endmodule
`default_nettype wire
